// File: rtl/gdsp_pkg.sv
// Shared constants and types for the GDSP channel/test blocks.
// The noise magnitude width is common to the AWGN generators and the sweep controller.
package gdsp_pkg;

    localparam int NOISE_MAG_WIDTH     = 8;

    localparam int SWEEP_DWELL_WIDTH   = 20;
    localparam int SWEEP_ERR_WIDTH     = 20;
    localparam int SWEEP_SETTLE_CYCLES = 8;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        MEASURE,
        REPORT,
        DONE
    } sweep_state_t;

endpackage

// File: rtl/snr_sweep_controller_meas_counter.sv
// Per-point symbol/error counter for the SNR sweep.
// Provides next-count values so the result register captures the completing strobe.
module sweep_meas_counter #(
    parameter int DWELL_WIDTH = 20,
    parameter int ERR_WIDTH   = 20
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   enable,
    input  logic                   sym_error,
    input  logic [DWELL_WIDTH-1:0] dwell,
    output logic [DWELL_WIDTH-1:0] sym_nxt,
    output logic [ERR_WIDTH-1:0]   err_nxt,
    output logic                   tc
);

    logic [DWELL_WIDTH-1:0] sym_cnt;
    logic [ERR_WIDTH-1:0]   err_cnt;
    logic [DWELL_WIDTH-1:0] dwell_eff;

    // A zero dwell still measures one symbol so every point yields a record.
    always_comb begin
        dwell_eff = (dwell == '0) ? DWELL_WIDTH'(1) : dwell;
        sym_nxt   = sym_cnt + DWELL_WIDTH'(1);
        err_nxt   = err_cnt;
        if (sym_error && (err_cnt != '1)) begin
            err_nxt = err_cnt + ERR_WIDTH'(1);
        end
        tc = enable && (sym_nxt == dwell_eff);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sym_cnt <= '0;
            err_cnt <= '0;
        end else if (clear) begin
            sym_cnt <= '0;
            err_cnt <= '0;
        end else if (enable) begin
            sym_cnt <= sym_nxt;
            err_cnt <= err_nxt;
        end
    end

endmodule

// File: rtl/snr_sweep_controller.sv
// Steps the AWGN noise magnitude through a programmed sweep and reports per-point BER counts.
//   state   | meaning
//   IDLE    | waiting for start, noise gated off
//   SETTLE  | new magnitude applied, flushing channel pipeline
//   MEASURE | counting received symbols and errors
//   REPORT  | result record offered, noise gated off
//   DONE    | one-cycle completion pulse
module snr_sweep_controller
    import gdsp_pkg::*;
#(
    parameter int DWELL_WIDTH   = SWEEP_DWELL_WIDTH,
    parameter int ERR_WIDTH     = SWEEP_ERR_WIDTH,
    parameter int SETTLE_CYCLES = SWEEP_SETTLE_CYCLES
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       abort,
    input  logic [NOISE_MAG_WIDTH-1:0] cfg_mag_start,
    input  logic [NOISE_MAG_WIDTH-1:0] cfg_mag_stop,
    input  logic [NOISE_MAG_WIDTH-1:0] cfg_mag_step,
    input  logic [DWELL_WIDTH-1:0]     cfg_dwell,
    input  logic                       sym_valid,
    input  logic                       sym_error,
    output logic                       noise_en,
    output logic [NOISE_MAG_WIDTH-1:0] noise_magnitude,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [NOISE_MAG_WIDTH-1:0] res_mag,
    output logic [DWELL_WIDTH-1:0]     res_sym_count,
    output logic [ERR_WIDTH-1:0]       res_err_count,
    output logic                       busy,
    output logic                       done
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);

    sweep_state_t state, state_nxt;

    logic [SW-1:0]              settle_cnt;
    logic [NOISE_MAG_WIDTH-1:0] mag_stop_q;
    logic [NOISE_MAG_WIDTH-1:0] mag_step_q;
    logic [DWELL_WIDTH-1:0]     dwell_q;
    logic [NOISE_MAG_WIDTH:0]   next_mag;
    logic                       sweep_last;
    logic                       meas_en;
    logic                       tc;
    logic [DWELL_WIDTH-1:0]     sym_nxt;
    logic [ERR_WIDTH-1:0]       err_nxt;

    // Extra bit keeps an overflowing step from wrapping back inside the range.
    assign next_mag   = {1'b0, noise_magnitude} + {1'b0, mag_step_q};
    assign sweep_last = (mag_step_q == '0) || (next_mag > {1'b0, mag_stop_q});
    assign meas_en    = (state == MEASURE) && sym_valid;

    assign noise_en  = (state == SETTLE) || (state == MEASURE);
    assign busy      = (state != IDLE);
    assign res_valid = (state == REPORT);
    assign done      = (state == DONE);

    sweep_meas_counter #(
        .DWELL_WIDTH (DWELL_WIDTH),
        .ERR_WIDTH   (ERR_WIDTH)
    ) u_meas (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (state == SETTLE),
        .enable    (meas_en),
        .sym_error (sym_error),
        .dwell     (dwell_q),
        .sym_nxt   (sym_nxt),
        .err_nxt   (err_nxt),
        .tc        (tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SETTLE;
            SETTLE:  if (settle_cnt == '0) state_nxt = MEASURE;
            MEASURE: if (tc) state_nxt = REPORT;
            REPORT:  if (res_ready) state_nxt = sweep_last ? DONE : SETTLE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt      <= '0;
            noise_magnitude <= '0;
            mag_stop_q      <= '0;
            mag_step_q      <= '0;
            dwell_q         <= '0;
            res_mag         <= '0;
            res_sym_count   <= '0;
            res_err_count   <= '0;
        end else if (abort) begin
            noise_magnitude <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        noise_magnitude <= cfg_mag_start;
                        mag_stop_q      <= cfg_mag_stop;
                        mag_step_q      <= cfg_mag_step;
                        dwell_q         <= cfg_dwell;
                        settle_cnt      <= SETTLE_LOAD;
                    end
                end
                SETTLE: begin
                    if (settle_cnt != '0) settle_cnt <= settle_cnt - SW'(1);
                end
                MEASURE: begin
                    if (tc) begin
                        res_mag       <= noise_magnitude;
                        res_sym_count <= sym_nxt;
                        res_err_count <= err_nxt;
                    end
                end
                REPORT: begin
                    if (res_ready && !sweep_last) begin
                        noise_magnitude <= next_mag[NOISE_MAG_WIDTH-1:0];
                        settle_cnt      <= SETTLE_LOAD;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_snr_sweep_controller.sv
// Directed bench for snr_sweep_controller: sweep vector table plus abort/reset sequences.
module tb_snr_sweep_controller;

    localparam int MW     = 8;
    localparam int DW     = 20;
    localparam int EW     = 4;
    localparam int SETTLE = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [MW-1:0] cfg_mag_start = '0;
    logic [MW-1:0] cfg_mag_stop = '0;
    logic [MW-1:0] cfg_mag_step = '0;
    logic [DW-1:0] cfg_dwell = '0;
    logic          sym_valid = 1'b0;
    logic          sym_error = 1'b0;
    logic          noise_en;
    logic [MW-1:0] noise_magnitude;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [MW-1:0] res_mag;
    logic [DW-1:0] res_sym_count;
    logic [EW-1:0] res_err_count;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    logic [63:0] err_mask = '0;
    bit          sym_on = 1'b0;
    int          ne_cnt = 0;
    int          ne_run = 0;
    int          done_cnt = 0;

    snr_sweep_controller #(
        .DWELL_WIDTH   (DW),
        .ERR_WIDTH     (EW),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .abort           (abort),
        .cfg_mag_start   (cfg_mag_start),
        .cfg_mag_stop    (cfg_mag_stop),
        .cfg_mag_step    (cfg_mag_step),
        .cfg_dwell       (cfg_dwell),
        .sym_valid       (sym_valid),
        .sym_error       (sym_error),
        .noise_en        (noise_en),
        .noise_magnitude (noise_magnitude),
        .res_valid       (res_valid),
        .res_ready       (res_ready),
        .res_mag         (res_mag),
        .res_sym_count   (res_sym_count),
        .res_err_count   (res_err_count),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    // Symbol source keyed to the bench's own count of noise-on cycles; settle strobes always carry errors.
    always @(negedge clk) begin
        int idx;
        if (noise_en) begin
            ne_cnt = ne_cnt + 1;
        end else begin
            if (ne_cnt != 0) ne_run = ne_cnt;
            ne_cnt = 0;
        end
        idx = ne_cnt - SETTLE;
        sym_valid = sym_on;
        sym_error = (idx >= 1 && idx < 64) ? err_mask[idx] : 1'b1;
        if (done) done_cnt = done_cnt + 1;
    end

    typedef struct {
        logic [MW-1:0] mag_start;
        logic [MW-1:0] mag_stop;
        logic [MW-1:0] mag_step;
        logic [DW-1:0] dwell;
        logic [63:0]   mask;
        int            ready_delay;
        int            exp_points;
        int            exp_mag_inc;
        int            exp_sym;
        int            exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_res(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            if (res_valid) ok = 1'b1;
        end
        if (!ok) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL res_valid_timeout: got 0 expected 1");
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_sweep(input int n, input vec_t v);
        bit ok;
        int dwell_eff;
        int exp_mag;
        int base_done;
        logic [MW-1:0] hold_mag;
        logic [DW-1:0] hold_sym;
        logic [EW-1:0] hold_err;
        bit stable;
        dwell_eff = (v.dwell == 0) ? 1 : int'(v.dwell);
        cfg_mag_start = v.mag_start;
        cfg_mag_stop  = v.mag_stop;
        cfg_mag_step  = v.mag_step;
        cfg_dwell     = v.dwell;
        err_mask      = v.mask;
        sym_on        = 1'b1;
        base_done     = done_cnt;
        pulse_start();
        check($sformatf("v%0d_start_mag", n), 64'(noise_magnitude), 64'(v.mag_start));
        check($sformatf("v%0d_start_en_busy", n), 64'({noise_en, busy}), 64'd3);
        for (int p = 0; p < v.exp_points; p++) begin
            exp_mag = int'(v.mag_start) + p * v.exp_mag_inc;
            wait_res(3000, ok);
            if (!ok) return;
            check($sformatf("v%0d_p%0d_res_mag", n, p), 64'(res_mag), 64'(exp_mag));
            check($sformatf("v%0d_p%0d_sym", n, p), 64'(res_sym_count), 64'(v.exp_sym));
            check($sformatf("v%0d_p%0d_err", n, p), 64'(res_err_count), 64'(v.exp_err));
            check($sformatf("v%0d_p%0d_noise_en_report", n, p), 64'(noise_en), 64'd0);
            check($sformatf("v%0d_p%0d_noise_on_cycles", n, p), 64'(ne_run), 64'(SETTLE + dwell_eff));
            if (v.ready_delay > 0) begin
                hold_mag = res_mag;
                hold_sym = res_sym_count;
                hold_err = res_err_count;
                stable = 1'b1;
                for (int i = 0; i < v.ready_delay; i++) begin
                    tick();
                    if (!res_valid || noise_en || res_mag !== hold_mag || res_sym_count !== hold_sym ||
                        res_err_count !== hold_err || noise_magnitude !== MW'(exp_mag)) stable = 1'b0;
                end
                check($sformatf("v%0d_p%0d_backpressure_hold", n, p), 64'(stable), 64'd1);
            end
            res_ready = 1'b1;
            tick();
            res_ready = 1'b0;
            if (p == v.exp_points - 1) begin
                check($sformatf("v%0d_done_pulse", n), 64'({done, res_valid}), 64'b10);
            end else begin
                check($sformatf("v%0d_p%0d_next_mag", n, p), 64'(noise_magnitude), 64'(exp_mag + v.exp_mag_inc));
                check($sformatf("v%0d_p%0d_next_settle", n, p), 64'({noise_en, res_valid}), 64'b10);
            end
        end
        tick();
        check($sformatf("v%0d_idle_after_done", n), 64'({done, busy}), 64'd0);
        check($sformatf("v%0d_done_count", n), 64'(done_cnt - base_done), 64'd1);
        sym_on = 1'b0;
        tick();
    endtask

    initial begin
        bit ok;
        int base_done;
        bit seen;

        vecs[0] = '{8'd8,   8'd32,  8'd8,  20'd16, 64'h0,                    0,  4, 8, 16, 0};
        vecs[1] = '{8'd5,   8'd5,   8'd1,  20'd10, 64'h224,                  0,  1, 0, 10, 3};
        vecs[2] = '{8'd100, 8'd100, 8'd0,  20'd20, 64'hFFFF_FFFF_FFFF_FFFE,  20, 1, 0, 20, 15};
        vecs[3] = '{8'd7,   8'd200, 8'd0,  20'd3,  64'h0,                    0,  1, 0, 3,  0};
        vecs[4] = '{8'd40,  8'd10,  8'd5,  20'd6,  64'h0,                    0,  1, 0, 6,  0};
        vecs[5] = '{8'd250, 8'd255, 8'd10, 20'd4,  64'h0,                    0,  1, 0, 4,  0};
        vecs[6] = '{8'd1,   8'd2,   8'd1,  20'd0,  64'h2,                    0,  2, 1, 1,  1};
        vecs[7] = '{8'd10,  8'd25,  8'd7,  20'd4,  64'h8,                    5,  3, 7, 4,  1};

        #12;
        check("reset_outputs", 64'({noise_en, noise_magnitude, res_valid, res_mag, res_sym_count,
                                     res_err_count, busy, done}), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        for (int n = 0; n < 8; n++) begin
            run_sweep(n, vecs[n]);
        end

        // Abort during MEASURE.
        cfg_mag_start = 8'd60; cfg_mag_stop = 8'd60; cfg_mag_step = 8'd0; cfg_dwell = 20'd50;
        err_mask = '0; sym_on = 1'b1; base_done = done_cnt;
        pulse_start();
        repeat (SETTLE + 5) tick();
        check("abort_pre_measuring", 64'({noise_en, res_valid}), 64'b10);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_idle", 64'({busy, noise_en, res_valid, noise_magnitude}), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (res_valid || busy) seen = 1'b1;
        end
        check("abort_no_result", 64'({seen, 32'(done_cnt - base_done)}), 64'd0);

        // Abort coincident with handshake.
        cfg_mag_start = 8'd1; cfg_mag_stop = 8'd9; cfg_mag_step = 8'd1; cfg_dwell = 20'd2;
        base_done = done_cnt;
        pulse_start();
        wait_res(200, ok);
        res_ready = 1'b1; abort = 1'b1;
        tick();
        res_ready = 1'b0; abort = 1'b0;
        check("abort_hs_idle", 64'({busy, done, noise_en, noise_magnitude}), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (res_valid || busy) seen = 1'b1;
        end
        check("abort_hs_no_done", 64'({seen, 32'(done_cnt - base_done)}), 64'd0);

        // Start and config changes ignored while busy.
        cfg_mag_start = 8'd50; cfg_mag_stop = 8'd50; cfg_mag_step = 8'd0; cfg_dwell = 20'd5;
        base_done = done_cnt;
        pulse_start();
        repeat (3) tick();
        cfg_mag_start = 8'd99; cfg_dwell = 20'd9;
        pulse_start();
        check("busy_start_ignored_mag", 64'(noise_magnitude), 64'd50);
        wait_res(200, ok);
        check("busy_start_res", 64'({res_mag, res_sym_count}), 64'({8'd50, 20'd5}));
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("busy_start_done", 64'(done), 64'd1);
        tick();
        check("busy_start_one_done", 64'({busy, 32'(done_cnt - base_done)}), 64'd1);

        // Start and abort together.
        cfg_mag_start = 8'd33;
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("start_abort_same", 64'({busy, noise_en, noise_magnitude}), 64'd0);

        // Asynchronous reset during SETTLE.
        cfg_mag_start = 8'd70; cfg_mag_stop = 8'd90; cfg_mag_step = 8'd5; cfg_dwell = 20'd5;
        pulse_start();
        repeat (3) tick();
        check("pre_reset_settle", 64'({noise_en, busy, noise_magnitude}), 64'({2'b11, 8'd70}));
        #2 rst_n = 1'b0;
        #1;
        check("reset_mid_settle", 64'({noise_en, noise_magnitude, res_valid, res_mag, res_sym_count,
                                        res_err_count, busy, done}), 64'd0);
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (res_valid || busy) seen = 1'b1;
        end
        check("reset_no_partial", 64'(seen), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
